// File: rtl/rv32_mem_pkg.sv
// Shared types and constants for the fetch/access memory port arbiter.
// State encoding, RV32 load/store funct3 codes and the store opcode.
package rv32_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IF_BUSY  = 2'd1,
        ST_ACC_BUSY = 2'd2
    } arb_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [3:0] BE_WORD  = 4'b1111;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles fetch, access-stage and memory-side signals of the arbiter.
// slave = arbiter view; master = pipeline plus memory view.
interface mem_port_arbiter_if #(parameter int ADDR_W = 32);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_ack;

    logic              acc_req;
    logic              acc_we;
    logic [2:0]        acc_funct3;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic [31:0]       acc_rdata;
    logic              acc_ack;
    logic              acc_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    logic              stall_if;
    logic              stall_acc;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ack,
        input  acc_req, acc_we, acc_funct3, acc_addr, acc_wdata,
        output acc_rdata, acc_ack, acc_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ready,
        output stall_if, stall_acc
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ack,
        output acc_req, acc_we, acc_funct3, acc_addr, acc_wdata,
        input  acc_rdata, acc_ack, acc_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ready,
        input  stall_if, stall_acc
    );

endinterface

// File: rtl/mem_port_arbiter_lane_align.sv
// Combinational byte-enable / store-lane steering and misalignment detect.
// Zero latency; no handshake.
module store_lane_align
    import rv32_mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic        we_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o
);

    logic [4:0] shamt;
    assign shamt = {addr_lo_i, 3'b000};

    always_comb begin
        be_o         = BE_WORD;
        wdata_o      = wdata_i;
        misaligned_o = 1'b0;
        case (funct3_i[1:0])
            2'b01:   misaligned_o = addr_lo_i[0];
            2'b10:   misaligned_o = |addr_lo_i;
            default: misaligned_o = 1'b0;
        endcase
        if (we_i) begin
            case (funct3_i)
                F3_B: begin
                    be_o    = 4'b0001 << addr_lo_i;
                    wdata_o = {24'd0, wdata_i[7:0]} << shamt;
                end
                F3_H: begin
                    be_o    = 4'b0011 << addr_lo_i;
                    wdata_o = {16'd0, wdata_i[15:0]} << shamt;
                end
                F3_W:    be_o = BE_WORD;
                // No store encoding exists for these; reject rather than write.
                default: misaligned_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch and access stage.
// Grant 1 cycle after request, ack 1 cycle after mem_ready; requests held by stall_* until ack.
module mem_port_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int FAIR_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
    localparam logic [3:0]        FAIR_MAX  = 4'(FAIR_LIMIT);

    arb_state_e        state_q;
    logic [3:0]        fair_cnt_q, fair_cnt_d;
    logic              mem_req_q, mem_we_q, err_pend_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       if_rdata_q, acc_rdata_q;
    logic              if_ack_q, acc_ack_q, acc_err_q;

    logic [3:0]        st_be;
    logic [31:0]       st_wdata;
    logic              st_misaligned;
    logic              if_v, acc_first, grant_acc, grant_if;

    store_lane_align u_lane (
        .funct3_i     (bus.acc_funct3),
        .addr_lo_i    (bus.acc_addr[1:0]),
        .wdata_i      (bus.acc_wdata),
        .we_i         (bus.acc_we),
        .be_o         (st_be),
        .wdata_o      (st_wdata),
        .misaligned_o (st_misaligned)
    );

    // An access request still high in its own ack cycle keeps priority but is
    // not re-granted; fetch only slips in when the fairness limit is reached.
    always_comb begin
        if_v      = bus.if_req & ~if_ack_q;
        acc_first = bus.acc_req & ~(if_v & (fair_cnt_q == FAIR_MAX));
        grant_acc = (state_q == ST_IDLE) & acc_first & ~acc_ack_q;
        grant_if  = (state_q == ST_IDLE) & if_v & ~acc_first;
        fair_cnt_d = fair_cnt_q;
        if (grant_if)
            fair_cnt_d = '0;
        else if (grant_acc && if_v && (fair_cnt_q < FAIR_MAX))
            fair_cnt_d = fair_cnt_q + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fair_cnt_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            err_pend_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            acc_rdata_q <= '0;
            if_ack_q    <= 1'b0;
            acc_ack_q   <= 1'b0;
            acc_err_q   <= 1'b0;
        end else begin
            if_ack_q   <= 1'b0;
            acc_ack_q  <= 1'b0;
            acc_err_q  <= 1'b0;
            fair_cnt_q <= fair_cnt_d;
            case (state_q)
                ST_IDLE: begin
                    if (grant_acc) begin
                        state_q     <= ST_ACC_BUSY;
                        err_pend_q  <= st_misaligned;
                        mem_req_q   <= ~st_misaligned;
                        mem_we_q    <= bus.acc_we & ~st_misaligned;
                        mem_addr_q  <= bus.acc_addr & WORD_MASK;
                        mem_wdata_q <= st_wdata;
                        mem_be_q    <= st_be;
                    end else if (grant_if) begin
                        state_q     <= ST_IF_BUSY;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.if_addr & WORD_MASK;
                        mem_wdata_q <= '0;
                        mem_be_q    <= BE_WORD;
                    end
                end
                ST_IF_BUSY: begin
                    if (bus.mem_ready) begin
                        state_q    <= ST_IDLE;
                        mem_req_q  <= 1'b0;
                        if_rdata_q <= bus.mem_rdata;
                        if_ack_q   <= 1'b1;
                    end
                end
                ST_ACC_BUSY: begin
                    if (err_pend_q) begin
                        state_q    <= ST_IDLE;
                        err_pend_q <= 1'b0;
                        acc_ack_q  <= 1'b1;
                        acc_err_q  <= 1'b1;
                    end else if (bus.mem_ready) begin
                        state_q     <= ST_IDLE;
                        mem_req_q   <= 1'b0;
                        acc_rdata_q <= bus.mem_rdata;
                        acc_ack_q   <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.acc_rdata = acc_rdata_q;
    assign bus.acc_ack   = acc_ack_q;
    assign bus.acc_err   = acc_err_q;
    assign bus.stall_if  = bus.if_req & ~if_ack_q;
    assign bus.stall_acc = bus.acc_req & ~acc_ack_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported data/instruction memory between the fetch stage and the memory-access stage.
- Arbitrates between the two requesters and sequences each transaction through a request/ready handshake.
- Generates byte enables for SB/SH/SW from funct3 and address, and detects misaligned data accesses.
- Produces the per-requester stall signals the pipeline control uses to freeze fetch and access.

Parameters:
- ADDR_W, 32, memory byte-address width.
- FAIR_LIMIT, 4, consecutive access-stage grants allowed while fetch is waiting; the next grant is forced to fetch. Range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch byte address, word-aligned.
- if_rdata  out  32  fetch data; valid while if_ack=1.
- if_ack  out  1  one-cycle fetch completion pulse.
- acc_req  in  1  access-stage request; held until acc_ack.
- acc_we  in  1  1=store, 0=load (from MemRW).
- acc_funct3  in  3  instruction[14:12] of the access-stage instruction.
- acc_addr  in  ADDR_W  alu_out of the access stage.
- acc_wdata  in  32  store data, unshifted (data_b).
- acc_rdata  out  32  raw load word; valid while acc_ack=1. Sign/zero extension is done downstream.
- acc_ack  out  1  one-cycle access completion pulse.
- acc_err  out  1  misaligned access; valid with acc_ack.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  ADDR_W  word address (byte address with [1:0] forced to 0), registered.
- mem_wdata  out  32  lane-shifted store data, registered.
- mem_be  out  4  byte enables, registered.
- mem_rdata  in  32  memory read data; valid with mem_ready.
- mem_ready  in  1  completes the current memory request.
- stall_if  out  1  if_req & ~if_ack (combinational).
- stall_acc  out  1  acc_req & ~acc_ack (combinational).

Behaviour:
- Reset values: all registered outputs 0, state IDLE, fairness counter 0. Reset is asynchronous: mem_req drops immediately. Any in-flight transaction is abandoned with no ack.
- States:
  - IDLE: arbitrate.
  - IF_BUSY: fetch transaction outstanding.
  - ACC_BUSY: access transaction outstanding.
- Request masking in IDLE: a requester whose ack is high in the current cycle is ignored, so a request is never granted twice.
- Arbitration in IDLE:
  - Access stage has priority.
  - If both are requesting and the fairness counter equals FAIR_LIMIT, fetch wins.
  - Counter increments on each access grant while if_req=1, and clears on any fetch grant.
- Grant:
  - On the grant edge, the mem_* outputs are loaded and mem_req=1.
  - The FSM moves to the matching BUSY state.
  - mem_* outputs stay stable until mem_ready.
- Completion:
  - In a BUSY state with mem_ready=1: mem_req goes to 0, mem_rdata is captured into the requester's rdata, and the requester's ack pulses high for exactly one cycle (the next cycle).
  - The FSM returns to IDLE.
- Latency:
  - Request at edge N with mem_ready tied high: mem_req is high after edge N+1, ack is high after edge N+2.
  - Maximum throughput is one transaction per 2 cycles.
- Byte enables, k = acc_addr[1:0]:
  - funct3 000 (SB): be = 1<<k; wdata lane k = wdata[7:0].
  - funct3 001 (SH): be = 0011<<k; lanes k and k+1 get wdata[15:0].
  - funct3 010 (SW): be = 1111.
  - Loads always use be = 1111.
  - Fetch always uses be = 1111, we = 0.
- Misalignment:
  - Halfword (funct3 x01) with addr[0]=1, or word (funct3 x10) with addr[1:0]!=0, is misaligned.
  - A misaligned access is granted but no memory request is issued. acc_ack=1 and acc_err=1 follow on the next cycle.
  - Unsupported funct3 (011, 11x) for a store: treated as misaligned.
- Simultaneous events: a mem_ready seen in IDLE is ignored.

Decomposition:
- Shared package rv32_mem_pkg:
  - FSM state encoding (IDLE=0, IF_BUSY=1, ACC_BUSY=2).
  - funct3 constants F3_B/H/W/BU/HU.
  - Opcode constant OP_STORE = 7'b0100011.
- Natural sub-module: store_lane_align. It is combinational and computes be, shifted wdata and misaligned from funct3, addr[1:0], wdata and we.

Test Plan:
- Single SW: acc_req=1, we=1, funct3=010, addr=0x104, wdata=0xDEADBEEF, mem_ready tied 1 -> mem_req high 1 cycle later with mem_addr=0x104, be=1111. acc_ack follows one cycle after that; stall_acc=1 until ack.
- SB at addr 0x203, wdata=0x000000A5 -> mem_be=1000, mem_wdata[31:24]=0xA5, mem_addr=0x200. SH at 0x202, wdata=0x1234 -> be=1100, mem_wdata[31:16]=0x1234.
- Misaligned SW at addr 0x102 -> mem_req stays 0; acc_ack=1 and acc_err=1 two cycles after request.
- Fairness: if_req and acc_req both held high, FAIR_LIMIT=4, every access re-requested -> grant order ACC,ACC,ACC,ACC,IF,ACC...; counter clears after the IF grant.
- Wait states: fetch at 0x40, mem_ready held low 5 cycles then pulsed with mem_rdata=0x00500093 -> mem_* stable for all 5 cycles; if_ack pulses once with if_rdata=0x00500093.
- Reset mid-transaction: assert rst while in ACC_BUSY -> mem_req=0 immediately, no acc_ack. After release, a new fetch request is granted normally.
